// File: rtl/prefetch_buf_pkg.sv
// Shared types for the instruction prefetch buffer.
//   pf_entry_t : one queue entry {word, word-aligned va, fault}
//   pf_state_e : fetch sequencer states
//   PF_PAGE_BITS : page offset width used for translation reuse
package prefetch_buf_pkg;

    localparam int unsigned PF_PAGE_BITS = 12;

    typedef struct packed {
        logic [31:0] word;
        logic [29:0] va;
        logic        fault;
    } pf_entry_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_XLATE,
        PF_FETCH,
        PF_FAULTED
    } pf_state_e;

endpackage

// File: rtl/prefetch_buf_fifo.sv
// DEPTH-entry circular queue of fetched words.
//   flush        : empties the queue (priority over push/pop)
//   push/push_e  : append one entry
//   pop          : drop the head entry
//   head/second  : the two oldest entries (valid per count)
//   count        : number of occupied entries
module prefetch_buf_fifo
    import prefetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  pf_entry_t                push_e,
    input  logic                     pop,
    output pf_entry_t                head,
    output pf_entry_t                second,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pf_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     wr_q;
    logic [CW-1:0]     cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_e;
    end

    assign head   = mem_q[rd_q];
    assign second = mem_q[rd_q + AW'(1)];
    assign count  = cnt_q;

endmodule

// File: rtl/prefetch_buf.sv
// Instruction prefetch buffer between IF, the ITLB and the I-cache.
// Runs ahead of IF filling a DEPTH-word queue, reuses one translation per
// page, and assembles 16/32-bit (including word-straddling) instructions.
//   IF side    : if_req_i, if_clear_i, if_pc_i -> instr_o, instr_pc_o,
//                valid_o, is_comp_o, page_fault_o, stall_o
//   MMU side   : mmu_req_o, mmu_vaddr_o <- mmu_paddr_i, mmu_hit_i,
//                mmu_page_fault_i
//   I-cache    : icache_req_o, icache_addr_o <- icache_rdata_i, icache_ack_i
module prefetch_buf
    import prefetch_buf_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAGE_BITS = PF_PAGE_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_i,
    input  logic            if_clear_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            valid_o,
    output logic            is_comp_o,
    output logic            page_fault_o,
    output logic            stall_o,
    output logic            mmu_req_o,
    output logic [XLEN-1:0] mmu_vaddr_o,
    input  logic [XLEN-1:0] mmu_paddr_i,
    input  logic            mmu_hit_i,
    input  logic            mmu_page_fault_i,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_addr_o,
    input  logic [31:0]     icache_rdata_i,
    input  logic            icache_ack_i
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned PPN_W = XLEN - PAGE_BITS;

    pf_state_e          state_q;
    logic [XLEN-1:0]    fetch_va_q;
    logic [XLEN-1:0]    pc_q;
    logic [PPN_W-1:0]   ppn_q;
    logic [PPN_W-1:0]   vpn_q;
    logic               ppn_valid_q;
    logic               drop_q;
    logic [XLEN-1:0]    ic_addr_q;

    pf_entry_t          w0;
    pf_entry_t          w1;
    pf_entry_t          push_e;
    logic [CW-1:0]      count;

    logic [15:0]        half_lo;
    logic               comp_c;
    logic               need2_c;
    logic               fault_c;
    logic               avail_c;
    logic [31:0]        instr_c;
    logic               take_c;
    logic               pop_c;
    logic               ack_push_c;
    logic               flt_push_c;
    logic               page_hit_c;
    logic [XLEN-1:0]    va_inc_c;
    logic               unused_bits;

    prefetch_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (if_clear_i),
        .push   (ack_push_c | flt_push_c),
        .push_e (push_e),
        .pop    (pop_c),
        .head   (w0),
        .second (w1),
        .count  (count)
    );

    // Instruction assembly from the two oldest queue entries.
    always_comb begin
        half_lo = pc_q[1] ? w0.word[31:16] : w0.word[15:0];
        comp_c  = (half_lo[1:0] != 2'b11);
        // A fault head carries a zero word, so it never asks for a second entry.
        need2_c = pc_q[1] & ~comp_c & ~w0.fault;
        fault_c = w0.fault | (need2_c & w1.fault);
        avail_c = (count != '0) & (~need2_c | (count > CW'(1)));
        instr_c = '0;
        if (avail_c && !fault_c) begin
            if (comp_c)       instr_c = {16'h0000, half_lo};
            else if (pc_q[1]) instr_c = {w1.word[15:0], w0.word[31:16]};
            else              instr_c = w0.word;
        end
    end

    // Consume/pop: the head leaves once pc moves past its word; faults are held.
    assign take_c = avail_c & ~fault_c & if_req_i & ~if_clear_i;
    assign pop_c  = take_c & (~comp_c | pc_q[1]);

    assign ack_push_c = (state_q == PF_FETCH) & icache_ack_i & ~drop_q & ~if_clear_i;
    assign flt_push_c = (state_q == PF_XLATE) & ~if_clear_i & ~mmu_hit_i & mmu_page_fault_i;
    assign push_e     = {(ack_push_c ? icache_rdata_i : 32'h0), fetch_va_q[XLEN-1:2], flt_push_c};

    assign page_hit_c = ppn_valid_q & (fetch_va_q[XLEN-1:PAGE_BITS] == vpn_q);
    assign va_inc_c   = fetch_va_q + XLEN'(4);

    // Fetch sequencer plus pc/fetch address bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PF_IDLE;
            fetch_va_q  <= '0;
            pc_q        <= '0;
            ppn_q       <= '0;
            vpn_q       <= '0;
            ppn_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            ic_addr_q   <= '0;
        end else begin
            if (take_c) pc_q <= pc_q + (comp_c ? XLEN'(2) : XLEN'(4));
            if (if_clear_i) begin
                pc_q       <= if_pc_i;
                fetch_va_q <= {if_pc_i[XLEN-1:2], 2'b00};
            end
            case (state_q)
                PF_IDLE: begin
                    // No request is in flight here, so a free slot is enough.
                    if (!if_clear_i && count < CW'(DEPTH)) begin
                        if (page_hit_c) begin
                            state_q   <= PF_FETCH;
                            ic_addr_q <= {ppn_q, fetch_va_q[PAGE_BITS-1:0]};
                        end else begin
                            state_q <= PF_XLATE;
                        end
                    end
                end
                PF_XLATE: begin
                    if (if_clear_i) begin
                        state_q <= PF_IDLE;
                    end else if (mmu_hit_i) begin
                        ppn_q       <= mmu_paddr_i[XLEN-1:PAGE_BITS];
                        vpn_q       <= fetch_va_q[XLEN-1:PAGE_BITS];
                        ppn_valid_q <= 1'b1;
                        ic_addr_q   <= {mmu_paddr_i[XLEN-1:PAGE_BITS], fetch_va_q[PAGE_BITS-1:0]};
                        state_q     <= PF_FETCH;
                    end else if (mmu_page_fault_i) begin
                        state_q <= PF_FAULTED;
                    end
                end
                PF_FETCH: begin
                    // The cache request cannot be withdrawn; a clear only marks it stale.
                    if (icache_ack_i) begin
                        state_q <= PF_IDLE;
                        drop_q  <= 1'b0;
                        if (!drop_q && !if_clear_i) begin
                            fetch_va_q <= va_inc_c;
                            if (va_inc_c[PAGE_BITS-1:0] == '0) ppn_valid_q <= 1'b0;
                        end
                    end else if (if_clear_i) begin
                        drop_q <= 1'b1;
                    end
                end
                PF_FAULTED: begin
                    if (if_clear_i) state_q <= PF_IDLE;
                end
                default: state_q <= PF_IDLE;
            endcase
        end
    end

    assign valid_o       = avail_c;
    assign page_fault_o  = avail_c & fault_c;
    assign is_comp_o     = avail_c & ~fault_c & comp_c;
    assign instr_o       = instr_c;
    assign instr_pc_o    = pc_q;
    assign stall_o       = if_req_i & ~avail_c;
    assign mmu_req_o     = (state_q == PF_XLATE);
    assign mmu_vaddr_o   = mmu_req_o ? fetch_va_q : '0;
    assign icache_req_o  = (state_q == PF_FETCH);
    assign icache_addr_o = icache_req_o ? ic_addr_q : '0;

    assign unused_bits = ^{w0.va, w1.va, w1.word[31:16], mmu_paddr_i[PAGE_BITS-1:0]};

endmodule
